// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port synchronous data RAM between the CPU MEM
// stage and a host load/readback port, sequencing the 1-cycle read latency.
// Optional feature: define DMEM_ARB_AGE_EN to let a host waiting MAX_WAIT
// cycles win over the CPU (default build: strict CPU priority).
module dmem_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic [DATA_W-1:0] o_cpu_rdata,
    output logic              o_cpu_stall,
    input  logic              i_host_req,
    input  logic              i_host_we,
    input  logic [ADDR_W-1:0] i_host_addr,
    input  logic [DATA_W-1:0] i_host_wdata,
    output logic              o_host_gnt,
    output logic              o_host_rvalid,
    output logic [DATA_W-1:0] o_host_rdata,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);
    typedef enum logic [1:0] {IDLE, RD_CPU, RD_HOST} state_t;
    localparam int AGE_W = $clog2(MAX_WAIT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MAX_WAIT);
    state_t              r_state;
    logic [DATA_W-1:0]   r_rdata;
    logic [AGE_W-1:0]    w_age;
    logic                w_idle, w_host_pri, w_cpu_win, w_host_win, w_rd_cpu, w_rd_host;
    assign w_idle     = (r_state == IDLE) & ~i_rst;
    assign w_rd_cpu   = (r_state == RD_CPU) & ~i_rst;
    assign w_rd_host  = (r_state == RD_HOST) & ~i_rst;
    assign w_host_pri = (w_age == AGE_MAX) & i_host_req;
    assign w_cpu_win  = w_idle & i_cpu_req & ~w_host_pri;
    assign w_host_win = w_idle & i_host_req & (~i_cpu_req | w_host_pri);
    // RAM port, grant, stall and read-data steering from the current winner/state
    always_comb begin
        o_mem_en      = w_cpu_win | w_host_win;
        o_mem_we      = w_cpu_win ? i_cpu_we    : w_host_win ? i_host_we    : 1'b0;
        o_mem_addr    = w_cpu_win ? i_cpu_addr  : w_host_win ? i_host_addr  : '0;
        o_mem_wdata   = w_cpu_win ? i_cpu_wdata : w_host_win ? i_host_wdata : '0;
        o_host_gnt    = w_host_win;
        o_host_rvalid = w_rd_host;
        o_host_rdata  = w_rd_host ? i_mem_rdata : '0;
        o_cpu_rdata   = w_rd_cpu ? i_mem_rdata : r_rdata;
        o_cpu_stall   = ~i_rst & i_cpu_req & ~(w_cpu_win & i_cpu_we) & ~w_rd_cpu;
    end
    // FSM: a granted read spends one cycle in RD_* while the RAM returns data
    always_ff @(posedge i_clk) begin
        if (i_rst)                       r_state <= IDLE;
        else if (w_cpu_win & ~i_cpu_we)  r_state <= RD_CPU;
        else if (w_host_win & ~i_host_we) r_state <= RD_HOST;
        else                             r_state <= IDLE;
    end
    // Hold the last CPU read so cpu_rdata stays stable after the release cycle
    always_ff @(posedge i_clk) begin
        if (i_rst)              r_rdata <= '0;
        else if (w_rd_cpu)      r_rdata <= i_mem_rdata;
    end
`ifdef DMEM_ARB_AGE_EN
    logic [AGE_W-1:0] r_age;
    // Count cycles a host request waits; saturation flips priority to the host
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_host_req || o_host_gnt) r_age <= '0;
        else if (r_age != AGE_MAX)              r_age <= r_age + 1'b1;
    end
    assign w_age = r_age;
`else
    assign w_age = '0;
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table-driven CPU vectors plus hand sequences for arbitration,
// host read latency, starvation/aging and reset-during-read.
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, host_req, host_we;
    logic [15:0] cpu_addr, host_addr;
    logic [31:0] cpu_wdata, host_wdata;
    logic [31:0] cpu_rdata, host_rdata, mem_wdata, mem_rdata;
    logic        cpu_stall, host_gnt, host_rvalid, mem_en, mem_we;
    logic [15:0] mem_addr;
    logic [31:0] ram [0:255];
    logic [31:0] sb [$];
    int          n_tests = 0;
    int          n_fail  = 0;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [10];

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(16), .DATA_W(32), .MAX_WAIT(8)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr),
        .i_cpu_wdata(cpu_wdata), .o_cpu_rdata(cpu_rdata), .o_cpu_stall(cpu_stall),
        .i_host_req(host_req), .i_host_we(host_we), .i_host_addr(host_addr),
        .i_host_wdata(host_wdata), .o_host_gnt(host_gnt), .o_host_rvalid(host_rvalid),
        .o_host_rdata(host_rdata), .o_mem_en(mem_en), .o_mem_we(mem_we),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
    );

    // Behavioural single-port synchronous RAM with 1-cycle read latency
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr[7:0]];
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one CPU access and wait (bounded) for its release cycle
    task automatic cpu_op(input logic we, input logic [15:0] addr, input logic [31:0] data,
                          input logic [31:0] exp);
        int  stalls = 0;
        bit  done = 0;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = data;
        if (!we) sb.push_back(exp);
        for (int c = 0; c < 6 && !done; c++) begin
            @(negedge clk);
            if (c == 0) begin
                check("cpu_issue_en", {31'd0, mem_en}, 32'd1);
                check("cpu_issue_we", {31'd0, mem_we}, {31'd0, we});
                check("cpu_issue_addr", {16'd0, mem_addr}, {16'd0, addr});
            end
            if (cpu_stall) stalls++;
            else begin
                done = 1;
                if (!we) check("cpu_rdata", cpu_rdata, sb.pop_front());
            end
            tick();
        end
        cpu_req = 1'b0;
        check("cpu_done", {31'd0, done}, 32'd1);
        check("cpu_stall_cycles", stalls, we ? 32'd0 : 32'd1);
    endtask

    initial begin
        int  gnt_at;
        bit  got_gnt;
        for (int i = 0; i < 256; i++) ram[i] = '0;
        mem_rdata = '0;
        rst = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0005; cpu_wdata = 32'h55;
        host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0006; host_wdata = 32'h66;
        tick(); tick();
        @(negedge clk);
        check("rst_stall", {31'd0, cpu_stall}, 32'd0);
        check("rst_mem_en", {31'd0, mem_en}, 32'd0);
        check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        check("rst_gnt", {31'd0, host_gnt}, 32'd0);
        check("rst_rvalid", {31'd0, host_rvalid}, 32'd0);
        check("rst_cpu_rdata", cpu_rdata, 32'd0);
        tick();
        cpu_req = 1'b0; host_req = 1'b0; rst = 1'b0;
        tick();

        // 1 + 2: CPU write then read-back
        cpu_op(1'b1, 16'h0010, 32'hDEADBEEF, 32'h0);
        cpu_op(1'b0, 16'h0010, 32'h0, 32'hDEADBEEF);
        @(negedge clk);
        check("cpu_rdata_hold", cpu_rdata, 32'hDEADBEEF);
        tick();

        vecs[0] = '{1'b1, 16'h0001, 32'h11111111, 32'h0};
        vecs[1] = '{1'b1, 16'h0002, 32'h22222222, 32'h0};
        vecs[2] = '{1'b0, 16'h0001, 32'h0, 32'h11111111};
        vecs[3] = '{1'b1, 16'h0001, 32'hAAAA5555, 32'h0};
        vecs[4] = '{1'b0, 16'h0001, 32'h0, 32'hAAAA5555};
        vecs[5] = '{1'b0, 16'h0002, 32'h0, 32'h22222222};
        vecs[6] = '{1'b1, 16'h00FF, 32'hFFFFFFFF, 32'h0};
        vecs[7] = '{1'b0, 16'h00FF, 32'h0, 32'hFFFFFFFF};
        vecs[8] = '{1'b0, 16'h0010, 32'h0, 32'hDEADBEEF};
        vecs[9] = '{1'b0, 16'h0002, 32'h0, 32'h22222222};
        for (int i = 0; i < 10; i++) cpu_op(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].exp);

        // 3: simultaneous CPU read and host write; CPU first, host at N+2
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0020; host_wdata = 32'h12345678;
        @(negedge clk);
        check("arb_n_addr", {16'd0, mem_addr}, 32'h10);
        check("arb_n_gnt", {31'd0, host_gnt}, 32'd0);
        check("arb_n_stall", {31'd0, cpu_stall}, 32'd1);
        tick();
        @(negedge clk);
        check("arb_n1_gnt", {31'd0, host_gnt}, 32'd0);
        check("arb_n1_stall", {31'd0, cpu_stall}, 32'd0);
        check("arb_n1_rdata", cpu_rdata, 32'hDEADBEEF);
        tick();
        cpu_req = 1'b0;
        @(negedge clk);
        check("arb_n2_gnt", {31'd0, host_gnt}, 32'd1);
        check("arb_n2_we", {31'd0, mem_we}, 32'd1);
        check("arb_n2_addr", {16'd0, mem_addr}, 32'h20);
        tick();
        host_req = 1'b0;
        check("ram_0x20", ram[8'h20], 32'h12345678);
        tick();

        // 4: host read alone; rvalid exactly one cycle after grant
        host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0020;
        @(negedge clk);
        check("hrd_gnt", {31'd0, host_gnt}, 32'd1);
        check("hrd_rvalid_n", {31'd0, host_rvalid}, 32'd0);
        if (host_gnt) sb.push_back(32'h12345678);
        tick();
        host_req = 1'b0;
        @(negedge clk);
        check("hrd_rvalid_n1", {31'd0, host_rvalid}, 32'd1);
        if (host_rvalid && sb.size() > 0) check("hrd_rdata", host_rdata, sb.pop_front());
        else check("hrd_rdata_present", {31'd0, host_rvalid}, 32'd1);
        tick();
        @(negedge clk);
        check("hrd_rvalid_n2", {31'd0, host_rvalid}, 32'd0);
        tick();

        // 5: continuous CPU reads against a held host read
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0020;
        got_gnt = 0; gnt_at = -1;
        for (int c = 0; c < 50 && !got_gnt; c++) begin
            @(negedge clk);
            if (host_gnt) begin got_gnt = 1; gnt_at = c; end
            tick();
        end
        host_req = 1'b0; cpu_req = 1'b0;
`ifdef DMEM_ARB_AGE_EN
        check("age_gnt_seen", {31'd0, got_gnt}, 32'd1);
        check("age_gnt_bound", {31'd0, (gnt_at >= 0 && gnt_at <= 10)}, 32'd1);
`else
        check("starve_no_gnt", {31'd0, got_gnt}, 32'd0);
`endif
        tick(); tick();

        // 6: reset during RD_HOST drops the read
        host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0020;
        @(negedge clk);
        check("rstrd_gnt", {31'd0, host_gnt}, 32'd1);
        tick();
        host_req = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("rstrd_rvalid", {31'd0, host_rvalid}, 32'd0);
        check("rstrd_rdata", host_rdata, 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_rvalid", {31'd0, host_rvalid}, 32'd0);
        check("post_rst_mem_en", {31'd0, mem_en}, 32'd0);
        check("post_rst_gnt", {31'd0, host_gnt}, 32'd0);
        check("post_rst_cpu_rdata", cpu_rdata, 32'd0);
        tick();
        cpu_op(1'b1, 16'h0030, 32'hCAFEF00D, 32'h0);
        cpu_op(1'b0, 16'h0030, 32'h0, 32'hCAFEF00D);
        check("sb_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
